// File: rtl/clock_pkg.sv
// Shared constants and counter-width helper for the digital-clock tick dividers.
package clock_pkg;

  localparam int CLK_HZ_BOARD     = 100000000;
  localparam int TICK_HZ_DEFAULT  = 1000;
  localparam int SLOW_DIV_DEFAULT = 1000;
  localparam int FAST_DIV_DEFAULT = 10;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int div_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo counter with a run-time terminal; wraps to 0 on the increment that
// finds the count at or beyond the terminal, so a lowered terminal never locks up.
module mod_counter
  import clock_pkg::*;
#(
  parameter int  MOD = 10,
  localparam int W   = div_width(MOD)
) (
  input  logic         clk_100M,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  input  logic [W-1:0] i_term,
  output logic [W-1:0] o_count,
  output logic         o_wrap
);

  logic [W-1:0] r_count;

  assign o_wrap  = i_inc && !i_clr && (r_count >= i_term);
  assign o_count = r_count;

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr || o_wrap) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/tick_divider.sv
// Prescaler + slow divider producing single-cycle enable ticks and a seconds square wave.
// Define TICK_DIVIDER_BLINK_EN to add the blink_2hz digit-blink output.
module tick_divider
  import clock_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_BOARD,
  parameter int TICK_HZ  = TICK_HZ_DEFAULT,
  parameter int SLOW_DIV = SLOW_DIV_DEFAULT,
  parameter int FAST_DIV = FAST_DIV_DEFAULT
) (
  input  logic clk_100M,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  input  logic fast_mode,
  output logic tick_1khz,
  output logic tick_1hz,
  output logic sq_1hz
`ifdef TICK_DIVIDER_BLINK_EN
  ,
  output logic blink_2hz
`endif
);

  localparam int PRE_DIV = CLK_HZ / TICK_HZ;
  localparam int WP      = div_width(PRE_DIV);
  localparam int WS      = div_width(SLOW_DIV);

  generate
    if (CLK_HZ % TICK_HZ != 0) begin : g_bad_ratio
      $fatal(1, "tick_divider: CLK_HZ must be a multiple of TICK_HZ");
    end
    if (PRE_DIV < 2) begin : g_bad_pre
      $fatal(1, "tick_divider: PRE_DIV must be at least 2");
    end
    if (SLOW_DIV < 2) begin : g_bad_slow
      $fatal(1, "tick_divider: SLOW_DIV must be at least 2");
    end
    if (FAST_DIV < 1 || FAST_DIV > SLOW_DIV) begin : g_bad_fast
      $fatal(1, "tick_divider: FAST_DIV must lie in 1..SLOW_DIV");
    end
  endgenerate

  logic          w_run;
  logic          w_pre_wrap;
  logic [WP-1:0] w_unused_pre_cnt;
  logic [WS-1:0] w_slow_term;
  logic [WS-1:0] w_slow_cnt;
  logic          w_slow_wrap;
  logic [WS-1:0] w_slow_next;
  logic [WS:0]   w_half;
  logic          r_tick_1khz;
  logic          r_tick_1hz;
  logic          r_sq_1hz;

  assign w_run       = en && !clr;
  assign w_slow_term = fast_mode ? WS'(FAST_DIV - 1) : WS'(SLOW_DIV - 1);
  assign w_half      = ({1'b0, w_slow_term} + 1'b1) >> 1;

  mod_counter #(.MOD(PRE_DIV)) u_pre (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .i_inc    (w_run),
    .i_clr    (clr),
    .i_term   (WP'(PRE_DIV - 1)),
    .o_count  (w_unused_pre_cnt),
    .o_wrap   (w_pre_wrap)
  );

  mod_counter #(.MOD(SLOW_DIV)) u_slow (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .i_inc    (w_pre_wrap),
    .i_clr    (clr),
    .i_term   (w_slow_term),
    .o_count  (w_slow_cnt),
    .o_wrap   (w_slow_wrap)
  );

  // Mirror of the slow counter's next state so sq_1hz flips on the tick_1hz cycle.
  always_comb begin
    w_slow_next = w_slow_cnt;
    if (clr || w_slow_wrap) begin
      w_slow_next = '0;
    end else if (w_pre_wrap) begin
      w_slow_next = w_slow_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_1khz <= 1'b0;
      r_tick_1hz  <= 1'b0;
      r_sq_1hz    <= 1'b1;
    end else begin
      r_tick_1khz <= w_pre_wrap;
      r_tick_1hz  <= w_slow_wrap;
      if (clr) begin
        r_sq_1hz <= 1'b1;
      end else if (en) begin
        r_sq_1hz <= ({1'b0, w_slow_next} < w_half);
      end
    end
  end

  assign tick_1khz = r_tick_1khz;
  assign tick_1hz  = r_tick_1hz;
  assign sq_1hz    = r_sq_1hz;

`ifdef TICK_DIVIDER_BLINK_EN
  localparam int BLINK_N = (SLOW_DIV / 4 < 1) ? 1 : SLOW_DIV / 4;
  localparam int BLINK_F = (FAST_DIV / 4 < 1) ? 1 : FAST_DIV / 4;
  localparam int WB      = div_width(BLINK_N);

  logic [WB-1:0] w_blink_term;
  logic [WB-1:0] w_unused_blink_cnt;
  logic          w_blink_wrap;
  logic          r_blink;

  assign w_blink_term = fast_mode ? WB'(BLINK_F - 1) : WB'(BLINK_N - 1);

  mod_counter #(.MOD(BLINK_N)) u_blink (
    .clk_100M (clk_100M),
    .rst_n    (rst_n),
    .i_inc    (w_pre_wrap),
    .i_clr    (clr),
    .i_term   (w_blink_term),
    .o_count  (w_unused_blink_cnt),
    .o_wrap   (w_blink_wrap)
  );

  always_ff @(posedge clk_100M or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= 1'b0;
    end else if (clr) begin
      r_blink <= 1'b0;
    end else if (w_blink_wrap) begin
      r_blink <= ~r_blink;
    end
  end

  assign blink_2hz = r_blink;
`endif

endmodule

// File: tb/tb_tick_divider.sv
// Directed bench for tick_divider with PRE_DIV=10, SLOW_DIV=10, FAST_DIV=2.
module tb_tick_divider;

  logic clk_100M  = 1'b0;
  logic rst_n     = 1'b0;
  logic en        = 1'b0;
  logic clr       = 1'b0;
  logic fast_mode = 1'b0;
  logic tick_1khz;
  logic tick_1hz;
  logic sq_1hz;
`ifdef TICK_DIVIDER_BLINK_EN
  logic blink_2hz;
`endif

  int checks = 0;
  int fails  = 0;
  int pos    = 0;

  always #5 clk_100M = ~clk_100M;

  tick_divider #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .SLOW_DIV (10),
    .FAST_DIV (2)
  ) dut (
    .clk_100M  (clk_100M),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .fast_mode (fast_mode),
    .tick_1khz (tick_1khz),
    .tick_1hz  (tick_1hz),
    .sq_1hz    (sq_1hz)
`ifdef TICK_DIVIDER_BLINK_EN
    ,
    .blink_2hz (blink_2hz)
`endif
  );

  task automatic step();
    @(posedge clk_100M);
    #1;
  endtask

  // Normal mode with en=1: pos counts enabled cycles since the last reset/clear.
  task automatic run_normal(input int n, input string tag);
    logic e_k, e_h, e_s;
    for (int i = 0; i < n; i++) begin
      step();
      pos++;
      e_k = (pos % 10 == 0);
      e_h = (pos % 100 == 0);
      e_s = ((pos % 100) < 50);
      checks++;
      if (tick_1khz !== e_k) begin
        fails++;
        $display("FAIL %s tick_1khz pos=%0d got=%b exp=%b", tag, pos, tick_1khz, e_k);
      end
      checks++;
      if (tick_1hz !== e_h) begin
        fails++;
        $display("FAIL %s tick_1hz pos=%0d got=%b exp=%b", tag, pos, tick_1hz, e_h);
      end
      checks++;
      if (sq_1hz !== e_s) begin
        fails++;
        $display("FAIL %s sq_1hz pos=%0d got=%b exp=%b", tag, pos, sq_1hz, e_s);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    step();
    step();
    checks++;
    if (tick_1khz !== 1'b0) begin fails++; $display("FAIL reset tick_1khz got=%b exp=0", tick_1khz); end
    checks++;
    if (tick_1hz !== 1'b0) begin fails++; $display("FAIL reset tick_1hz got=%b exp=0", tick_1hz); end
    checks++;
    if (sq_1hz !== 1'b1) begin fails++; $display("FAIL reset sq_1hz got=%b exp=1", sq_1hz); end
    $display("reset: tick_1khz=%b tick_1hz=%b sq_1hz=%b", tick_1khz, tick_1hz, sq_1hz);
  endtask

  task automatic test_run();
    rst_n = 1'b1;
    pos   = 0;
    run_normal(250, "run");
    $display("run: 250 cycles normal mode, pos=%0d", pos);
  endtask

  task automatic test_enable_hold();
    run_normal(9, "pre_hold");
    en = 1'b0;
    for (int i = 0; i < 37; i++) begin
      step();
      checks++;
      if (tick_1khz !== 1'b0) begin fails++; $display("FAIL hold tick_1khz cyc=%0d got=%b exp=0", i, tick_1khz); end
      checks++;
      if (tick_1hz !== 1'b0) begin fails++; $display("FAIL hold tick_1hz cyc=%0d got=%b exp=0", i, tick_1hz); end
      checks++;
      if (sq_1hz !== 1'b0) begin fails++; $display("FAIL hold sq_1hz cyc=%0d got=%b exp=0", i, sq_1hz); end
    end
    en = 1'b1;
    run_normal(51, "resume");
    $display("enable_hold: 37 idle cycles, resumed to pos=%0d", pos);
  endtask

  task automatic test_clear();
    run_normal(69, "pre_clr");
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (tick_1khz !== 1'b0) begin fails++; $display("FAIL clr tick_1khz got=%b exp=0", tick_1khz); end
    checks++;
    if (tick_1hz !== 1'b0) begin fails++; $display("FAIL clr tick_1hz got=%b exp=0", tick_1hz); end
    checks++;
    if (sq_1hz !== 1'b1) begin fails++; $display("FAIL clr sq_1hz got=%b exp=1", sq_1hz); end
    pos = 0;
    run_normal(160, "post_clr");
    en  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (sq_1hz !== 1'b1) begin fails++; $display("FAIL clr_en0 sq_1hz got=%b exp=1", sq_1hz); end
    checks++;
    if (tick_1khz !== 1'b0) begin fails++; $display("FAIL clr_en0 tick_1khz got=%b exp=0", tick_1khz); end
    en  = 1'b1;
    pos = 0;
    run_normal(65, "pre_fast");
    $display("clear: counters restarted, pos=%0d", pos);
  endtask

  // Raised at slow_cnt=6, pre_cnt=5: overshoot wraps on the next fast tick (f=5).
  task automatic test_fast_mode();
    logic e_k, e_h, e_s;
    fast_mode = 1'b1;
    for (int f = 1; f <= 55; f++) begin
      step();
      e_k = (f % 10 == 5);
      e_h = (f >= 5) && ((f - 5) % 20 == 0);
      e_s = (f >= 5) && ((f - 5) % 20 < 10);
      checks++;
      if (tick_1khz !== e_k) begin fails++; $display("FAIL fast tick_1khz f=%0d got=%b exp=%b", f, tick_1khz, e_k); end
      checks++;
      if (tick_1hz !== e_h) begin fails++; $display("FAIL fast tick_1hz f=%0d got=%b exp=%b", f, tick_1hz, e_h); end
      checks++;
      if (sq_1hz !== e_s) begin fails++; $display("FAIL fast sq_1hz f=%0d got=%b exp=%b", f, sq_1hz, e_s); end
    end
    $display("fast_mode: 55 cycles checked");
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (tick_1khz !== 1'b0) begin fails++; $display("FAIL areset tick_1khz got=%b exp=0", tick_1khz); end
    checks++;
    if (tick_1hz !== 1'b0) begin fails++; $display("FAIL areset tick_1hz got=%b exp=0", tick_1hz); end
    checks++;
    if (sq_1hz !== 1'b1) begin fails++; $display("FAIL areset sq_1hz got=%b exp=1", sq_1hz); end
    fast_mode = 1'b0;
    #27;
    checks++;
    if (tick_1khz !== 1'b0) begin fails++; $display("FAIL areset_hold tick_1khz got=%b exp=0", tick_1khz); end
    #3;
    rst_n = 1'b1;
    pos   = 0;
    run_normal(30, "post_rst");
    $display("async_reset: resumed from zero, pos=%0d", pos);
  endtask

`ifdef TICK_DIVIDER_BLINK_EN
  task automatic test_blink();
    logic e_b;
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (blink_2hz !== 1'b0) begin fails++; $display("FAIL blink_clr got=%b exp=0", blink_2hz); end
    pos = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      pos++;
      e_b = ((pos / 20) % 2 == 1);
      checks++;
      if (blink_2hz !== e_b) begin fails++; $display("FAIL blink_norm pos=%0d got=%b exp=%b", pos, blink_2hz, e_b); end
    end
    clr       = 1'b1;
    fast_mode = 1'b1;
    step();
    clr = 1'b0;
    pos = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      pos++;
      e_b = ((pos / 10) % 2 == 1);
      checks++;
      if (blink_2hz !== e_b) begin fails++; $display("FAIL blink_fast pos=%0d got=%b exp=%b", pos, blink_2hz, e_b); end
    end
    fast_mode = 1'b0;
    $display("blink: normal and fast periods checked");
  endtask
`endif

  initial begin
    test_reset();
    test_run();
    test_enable_hold();
    test_clear();
    test_fast_mode();
    test_async_reset();
`ifdef TICK_DIVIDER_BLINK_EN
    test_blink();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
